// File: rtl/iaoq_pkg.sv
// Shared types and helpers for the instruction address offset queue.
// Holds the Q-bit state encoding and the interruption vector arithmetic.
// No logic of its own; imported by iaoq_unit.
package iaoq_pkg;

  // Q-bit: ON means interruption state is collected into the shadows.
  typedef enum logic {
    Q_ON  = 1'b0,
    Q_OFF = 1'b1
  } q_state_e;

  // Each vector entry is 32 bytes apart.
  localparam int IVA_STRIDE_SH = 5;

  // Wide enough for any practical address width; callers truncate.
  localparam int VEC_CALC_W = 64;

  // Vector address = base + code * 32 (modulo the caller's width).
  function automatic logic [VEC_CALC_W-1:0] iaoq_vector(
    input logic [VEC_CALC_W-1:0] base,
    input logic [VEC_CALC_W-1:0] code
  );
    return base + (code << IVA_STRIDE_SH);
  endfunction

endpackage

// File: rtl/iaoq_reg.sv
// Generic WIDTH-bit register with load enable.
// Latency: 1 cycle from d to q when en is high.
// Backpressure: none; holds value while en is low.
module iaoq_reg #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Load on enable; asynchronous reset to RST_VAL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/iaoq_unit.sv
// PA-RISC instruction address offset queue (front/back) with interruption shadows.
// Latency: 1 cycle, all outputs registered; no input-to-output combinational path.
// Backpressure: stall freezes everything except a trap, which always vectors.
module iaoq_unit
  import iaoq_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               INC       = 4,
  parameter logic [WIDTH-1:0] RST_FRONT = 32'h0,
  parameter logic [WIDTH-1:0] RST_BACK  = 32'h4,
  parameter logic [WIDTH-1:0] IVA_BASE  = 32'h0000_0800,
  parameter int               CODE_W    = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [WIDTH-1:0]  br_target,
  input  logic              trap,
  input  logic [CODE_W-1:0] trap_code,
  input  logic              rfi,
  output logic [WIDTH-1:0]  iaoq_front,
  output logic [WIDTH-1:0]  iaoq_back,
  output logic [WIDTH-1:0]  iiaoq_front,
  output logic [WIDTH-1:0]  iiaoq_back,
  output logic              q_on,
  output logic              double_trap
);

  // Every address loaded into the queue is word aligned.
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

  logic [WIDTH-1:0] front_q, back_q, ifront_q, iback_q;
  logic [WIDTH-1:0] front_d, back_d, vec;
  logic             queue_en, shadow_en;
  logic             dtrap_q, dtrap_d;
  q_state_e         state_q, state_d;

  assign vec = WIDTH'(iaoq_vector(VEC_CALC_W'(IVA_BASE), VEC_CALC_W'(trap_code)));

  // Priority mux: trap > stall > rfi (Q_OFF only) > branch > sequential.
  always_comb begin
    front_d   = front_q;
    back_d    = back_q;
    state_d   = state_q;
    queue_en  = 1'b0;
    shadow_en = 1'b0;
    dtrap_d   = 1'b0;
    if (trap) begin
      queue_en = 1'b1;
      front_d  = vec;
      back_d   = vec + WIDTH'(INC);
      // Shadows are only captured while collection is enabled.
      if (state_q == Q_ON) begin
        shadow_en = 1'b1;
        state_d   = Q_OFF;
      end else begin
        dtrap_d = 1'b1;
      end
    end else if (!stall) begin
      queue_en = 1'b1;
      if (rfi && state_q == Q_OFF) begin
        front_d = ifront_q;
        back_d  = iback_q;
        state_d = Q_ON;
      end else if (br_taken) begin
        front_d = back_q;
        back_d  = br_target;
      end else begin
        front_d = back_q;
        back_d  = back_q + WIDTH'(INC);
      end
    end
    front_d = front_d & ALIGN_MASK;
    back_d  = back_d & ALIGN_MASK;
  end

  // Q-bit state and the one-cycle double-trap pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= Q_ON;
      dtrap_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dtrap_q <= dtrap_d;
    end
  end

  iaoq_reg #(.WIDTH(WIDTH), .RST_VAL(RST_FRONT)) u_front (
    .clk(clk), .rst(reset), .en(queue_en), .d(front_d), .q(front_q)
  );

  iaoq_reg #(.WIDTH(WIDTH), .RST_VAL(RST_BACK)) u_back (
    .clk(clk), .rst(reset), .en(queue_en), .d(back_d), .q(back_q)
  );

  iaoq_reg #(.WIDTH(WIDTH), .RST_VAL('0)) u_ifront (
    .clk(clk), .rst(reset), .en(shadow_en), .d(front_q), .q(ifront_q)
  );

  iaoq_reg #(.WIDTH(WIDTH), .RST_VAL('0)) u_iback (
    .clk(clk), .rst(reset), .en(shadow_en), .d(back_q), .q(iback_q)
  );

  assign iaoq_front  = front_q;
  assign iaoq_back   = back_q;
  assign iiaoq_front = ifront_q;
  assign iiaoq_back  = iback_q;
  assign q_on        = (state_q == Q_ON);
  assign double_trap = dtrap_q;

endmodule

// File: tb/tb_iaoq_unit.sv
// Self-checking bench for iaoq_unit: directed scenarios then random traffic.
// Reference model tracks the architectural queue with plain 32-bit arithmetic.
// Async reset is exercised mid-cycle, away from clock edges.
module tb_iaoq_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, br_taken, trap, rfi;
  logic [31:0] br_target;
  logic [4:0]  trap_code;
  logic [31:0] iaoq_front, iaoq_back, iiaoq_front, iiaoq_back;
  logic        q_on, double_trap;

  iaoq_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .trap(trap), .trap_code(trap_code), .rfi(rfi),
    .iaoq_front(iaoq_front), .iaoq_back(iaoq_back),
    .iiaoq_front(iiaoq_front), .iiaoq_back(iiaoq_back),
    .q_on(q_on), .double_trap(double_trap)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Architectural state of the reference model.
  logic [31:0] m_front, m_back, m_ifront, m_iback;
  logic        m_qon, m_dt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_front = 32'h0; m_back = 32'h4; m_ifront = 32'h0; m_iback = 32'h0;
    m_qon = 1'b1; m_dt = 1'b0;
  endtask

  // One architectural cycle, from the current inputs.
  task automatic model_cycle();
    logic [31:0] v;
    m_dt = 1'b0;
    if (trap) begin
      v = 32'h800 + 32'(trap_code) * 32;
      if (m_qon) begin
        m_ifront = m_front;
        m_iback  = m_back;
        m_qon    = 1'b0;
      end else begin
        m_dt = 1'b1;
      end
      m_front = v;
      m_back  = v + 4;
    end else if (!stall) begin
      if (rfi && !m_qon) begin
        m_front = m_ifront;
        m_back  = m_iback;
        m_qon   = 1'b1;
      end else if (br_taken) begin
        m_front = m_back;
        m_back  = {br_target[31:2], 2'b00};
      end else begin
        m_front = m_back;
        m_back  = m_back + 4;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".front"}, iaoq_front, m_front);
    check({tag, ".back"}, iaoq_back, m_back);
    check({tag, ".ifront"}, iiaoq_front, m_ifront);
    check({tag, ".iback"}, iiaoq_back, m_iback);
    check({tag, ".q_on"}, 32'(q_on), 32'(m_qon));
    check({tag, ".dtrap"}, 32'(double_trap), 32'(m_dt));
  endtask

  // Drive inputs just after an edge, clock once, sample 1 ns after the edge.
  task automatic step(input string tag, input logic s, input logic b, input logic [31:0] t,
                      input logic tr, input logic [4:0] c, input logic r);
    stall = s; br_taken = b; br_target = t; trap = tr; trap_code = c; rfi = r;
    model_cycle();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0);
  endtask

  // Assert reset between edges; outputs must follow without a clock.
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    stall = 0; br_taken = 0; br_target = 0; trap = 0; trap_code = 0; rfi = 0;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("reset");
    check("reset.back_const", iaoq_back, 32'h4);
    @(negedge clk);
    reset = 1'b0;

    // Sequential advance and delayed branch.
    idle("seq1");
    check("seq1.const", {iaoq_front[15:0], iaoq_back[15:0]}, 32'h0004_0008);
    idle("seq2");
    step("br", 1'b0, 1'b1, 32'h100, 1'b0, 5'd0, 1'b0);
    check("br.const", {iaoq_front[15:0], iaoq_back[15:0]}, 32'h000C_0100);
    idle("br_slot");
    check("br_slot.const", {iaoq_front[15:0], iaoq_back[15:0]}, 32'h0100_0104);

    // Trap vectoring and RFI from 10/14.
    async_reset("rst2");
    repeat (4) idle("seq");
    step("trap3", 1'b0, 1'b0, 32'h0, 1'b1, 5'd3, 1'b0);
    check("trap3.front_const", iaoq_front, 32'h860);
    check("trap3.ifront_const", iiaoq_front, 32'h10);
    step("rfi", 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b1);
    check("rfi.back_const", iaoq_back, 32'h14);

    // Double trap: shadows preserved, one-cycle pulse.
    step("trapA", 1'b0, 1'b0, 32'h0, 1'b1, 5'd3, 1'b0);
    step("trap1", 1'b0, 1'b0, 32'h0, 1'b1, 5'd1, 1'b0);
    check("trap1.front_const", iaoq_front, 32'h820);
    check("trap1.dtrap_const", 32'(double_trap), 32'h1);
    idle("dt_clear");
    step("rfi2", 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b1);

    // Stall drops branches; a trap during stall still vectors.
    repeat (3) step("stall_br", 1'b1, 1'b1, 32'h4000, 1'b0, 5'd0, 1'b0);
    step("stall_trap", 1'b1, 1'b0, 32'h0, 1'b1, 5'd7, 1'b1);
    step("rfi3", 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b1);

    // Wrap of back past the top of the address space.
    step("br_top", 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 5'd0, 1'b0);
    idle("wrap");
    check("wrap.back_const", iaoq_back, 32'h0);
    step("trapW", 1'b0, 1'b0, 32'h0, 1'b1, 5'd31, 1'b0);
    async_reset("rst_qoff");

    // Random traffic with occasional mid-cycle resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        async_reset("rnd_rst");
      end else begin
        step("rnd",
             ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 3) == 0),
             $urandom(),
             ($urandom_range(0, 9) == 0),
             5'($urandom_range(0, 31)),
             ($urandom_range(0, 4) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
